// File: rtl/aes_key_expander.sv
// -----------------------------------------------------------------------------
// aes_key_expander
// Iterative AES-128 / AES-256 key schedule. One 128-bit round key is produced
// per clock and kept in an internal register store. The store is read
// combinationally by round number.
// Optional feature macro: AES_KEY_ZEROIZE_EN adds a zeroize input that wipes
// the store and the working registers and returns the block to IDLE.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module aes_key_expander #(
    parameter int KEY_BITS = 256
) (
    input  logic                clk,
    input  logic                reset,
`ifdef AES_KEY_ZEROIZE_EN
    input  logic                zeroize,
`endif
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                busy,
    output logic                ready,
    input  logic [3:0]          rd_round,
    output logic [127:0]        rd_key
);

    localparam int NK  = KEY_BITS / 32;
    localparam int NR  = NK + 6;
    localparam int NRK = NR + 1;

    // First round index produced by the iteration: AES-256 gets two keys from the cipher key.
    localparam logic [3:0] FIRST_CTR = 4'(NK / 4);
    localparam logic [3:0] LAST_CTR  = 4'(NR);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_key_expander: KEY_BITS must be 128 or 256");
    end

    // FIPS-197 S-box, entry 0 in the MSBs.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry x sits at bit offset (255-x)*8, and ~x is exactly 255-x.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    genvar gi;

    logic         zeroize_w;
    logic [1:0]   state_q, state_d;
    logic [127:0] prev0_q, prev0_d;   // round key round_ctr-2 (AES-256 XOR source)
    logic [127:0] prev1_q, prev1_d;   // round key round_ctr-1 (last word feeds t)
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   round_ctr_q, round_ctr_d;

    logic         accept;
    logic         expand_we;
    logic         odd_step;
    logic [31:0]  last_word;
    logic [31:0]  sbox_in;
    logic [31:0]  sub_word;
    logic [31:0]  t_word;
    logic [127:0] xor_src;
    logic [31:0]  k0, k1, k2, k3;
    logic [127:0] new_rk;
    logic [127:0] rk_w [NRK];

`ifdef AES_KEY_ZEROIZE_EN
    assign zeroize_w = zeroize;
`else
    assign zeroize_w = 1'b0;
`endif

    assign accept    = (state_q == ST_IDLE || state_q == ST_DONE) && start && !zeroize_w;
    assign expand_we = (state_q == ST_EXPAND);

    // AES-256 odd rounds use SubWord only; all other steps use RotWord+SubWord+rcon.
    assign odd_step  = (NK == 8) && round_ctr_q[0];
    assign last_word = prev1_q[31:0];
    assign sbox_in   = odd_step ? last_word : {last_word[23:0], last_word[31:24]};

    for (gi = 0; gi < 4; gi++) begin : g_sbox
        assign sub_word[gi*8 +: 8] = sbox(sbox_in[gi*8 +: 8]);
    end

    assign t_word  = odd_step ? sub_word : (sub_word ^ {rcon_q, 24'h0});
    assign xor_src = (NK == 8) ? prev0_q : prev1_q;
    assign k0      = xor_src[127:96] ^ t_word;
    assign k1      = xor_src[95:64]  ^ k0;
    assign k2      = xor_src[63:32]  ^ k1;
    assign k3      = xor_src[31:0]   ^ k2;
    assign new_rk  = {k0, k1, k2, k3};

    // Next-state logic for the FSM and the iteration registers.
    always_comb begin
        state_d     = state_q;
        prev0_d     = prev0_q;
        prev1_d     = prev1_q;
        rcon_d      = rcon_q;
        round_ctr_d = round_ctr_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_EXPAND;
                    prev0_d     = key_in[KEY_BITS-1 -: 128];
                    prev1_d     = key_in[127:0];
                    rcon_d      = 8'h01;
                    round_ctr_d = FIRST_CTR;
                end
            end
            ST_EXPAND: begin
                prev0_d     = prev1_q;
                prev1_d     = new_rk;
                round_ctr_d = round_ctr_q + 4'd1;
                if (!odd_step) begin
                    rcon_d = xtime(rcon_q);
                end
                if (round_ctr_q == LAST_CTR) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Working registers; zeroize outranks any start in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            prev0_q     <= '0;
            prev1_q     <= '0;
            rcon_q      <= 8'h01;
            round_ctr_q <= '0;
        end else if (zeroize_w) begin
            state_q     <= ST_IDLE;
            prev0_q     <= '0;
            prev1_q     <= '0;
            rcon_q      <= 8'h01;
            round_ctr_q <= '0;
        end else begin
            state_q     <= state_d;
            prev0_q     <= prev0_d;
            prev1_q     <= prev1_d;
            rcon_q      <= rcon_d;
            round_ctr_q <= round_ctr_d;
        end
    end

    // Key store: one register per round key, filled either from key_in or from the iteration.
    for (gi = 0; gi < NRK; gi++) begin : g_store
        logic         we;
        logic [127:0] wdata;
        logic [127:0] entry_q;

        if (gi == 0) begin : g_from_key_hi
            assign we    = accept;
            assign wdata = key_in[KEY_BITS-1 -: 128];
        end else if (gi == 1 && NK == 8) begin : g_from_key_lo
            assign we    = accept;
            assign wdata = key_in[127:0];
        end else begin : g_from_iter
            assign we    = expand_we && (round_ctr_q == 4'(gi));
            assign wdata = new_rk;
        end

        // Hold one round key; cleared by reset or zeroize.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                entry_q <= '0;
            end else if (zeroize_w) begin
                entry_q <= '0;
            end else if (we) begin
                entry_q <= wdata;
            end
        end

        assign rk_w[gi] = entry_q;
    end

    assign busy   = (state_q == ST_EXPAND);
    assign ready  = (state_q == ST_DONE);
    assign rd_key = (rd_round <= LAST_CTR) ? rk_w[rd_round] : '0;

endmodule

// File: tb/tb_aes_key_expander.sv
// -----------------------------------------------------------------------------
// tb_aes_key_expander
// Drives an AES-128 and an AES-256 instance side by side and checks every
// round key against a word-oriented FIPS-197 key schedule whose S-box is
// derived from GF(2^8) inversion plus the affine map.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aes_key_expander;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic         reset;
    logic         start_a, start_b;
    logic [127:0] key_a;
    logic [255:0] key_b;
    logic         busy_a, busy_b, ready_a, ready_b;
    logic [3:0]   rd_a, rd_b;
    logic [127:0] rdk_a, rdk_b;
`ifdef AES_KEY_ZEROIZE_EN
    logic         zero_a, zero_b;
`endif

    aes_key_expander #(.KEY_BITS(128)) u_dut128 (
        .clk(clk), .reset(reset),
`ifdef AES_KEY_ZEROIZE_EN
        .zeroize(zero_a),
`endif
        .start(start_a), .key_in(key_a), .busy(busy_a), .ready(ready_a),
        .rd_round(rd_a), .rd_key(rdk_a)
    );

    aes_key_expander #(.KEY_BITS(256)) u_dut256 (
        .clk(clk), .reset(reset),
`ifdef AES_KEY_ZEROIZE_EN
        .zeroize(zero_b),
`endif
        .start(start_b), .key_in(key_b), .busy(busy_b), .ready(ready_b),
        .rd_round(rd_b), .rd_key(rdk_b)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0]   sbox_ref [256];
    logic [127:0] ref_rk   [15];

    localparam logic [255:0] T1_KEY = {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
    localparam logic [255:0] T2_KEY =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
        logic [15:0] d;
        d = {x, x} << k;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_ref[w[31:24]], sbox_ref[w[23:16]], sbox_ref[w[15:8]], sbox_ref[w[7:0]]};
    endfunction

    // Key is right-aligned: AES-128 keys live in key[127:0].
    task automatic expand_ref(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[(nk-1-i)*32 +: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 4 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 15; r++)
            ref_rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic s, input logic [255:0] k);
        if (sel == 0) begin start_a = s; key_a = k[127:0]; end
        else          begin start_b = s; key_b = k;        end
    endtask

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? ready_a : ready_b;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy_a : busy_b;
    endfunction

    task automatic rd(input int sel, input int r, output logic [127:0] v);
        if (sel == 0) rd_a = 4'(r); else rd_b = 4'(r);
        #1;
        v = (sel == 0) ? rdk_a : rdk_b;
    endtask

    task automatic check_store(input int sel, input logic [255:0] key, input string tag);
        logic [127:0] v;
        int nk;
        nk = (sel == 0) ? 4 : 8;
        expand_ref(key, nk);
        for (int r = 0; r < 16; r++) begin
            rd(sel, r, v);
            chk($sformatf("%s_rk%0d", tag, r), v, (r < 15) ? ref_rk[r] : 128'h0);
        end
    endtask

    task automatic check_zero(input int sel, input string tag);
        logic [127:0] v;
        for (int r = 0; r < 16; r++) begin
            rd(sel, r, v);
            chk($sformatf("%s_zero%0d", tag, r), v, 128'h0);
        end
    endtask

    // One expansion: optional start held high with another key during EXPAND.
    task automatic run(input int sel, input logic [255:0] key, input bit hold, input string tag);
        int lat, edges;
        lat = (sel == 0) ? 11 : 14;
        drive(sel, 1'b1, key);
        tick();
        edges = 1;
        chk({tag, "_ready_low_on_accept"}, 128'(get_ready(sel)), 128'h0);
        chk({tag, "_busy_on_accept"}, 128'(get_busy(sel)), 128'h1);
        if (hold) drive(sel, 1'b1, ~key);
        else      drive(sel, 1'b0, key);
        while (!get_ready(sel) && edges < 40) begin
            tick();
            edges++;
            if (hold && edges >= lat - 1) drive(sel, 1'b0, key);
        end
        drive(sel, 1'b0, key);
        chk({tag, "_latency"}, 128'(edges), 128'(lat));
        chk({tag, "_busy_done"}, 128'(get_busy(sel)), 128'h0);
        $display("[TB] %s: KEY_BITS=%0d key=%h hold=%0d latency=%0d",
                 tag, (sel == 0) ? 128 : 256, key, hold, edges);
        check_store(sel, key, tag);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] v;
        logic [255:0] rk;

        reset = 1'b1;
        start_a = 1'b0; start_b = 1'b0; key_a = '0; key_b = '0; rd_a = '0; rd_b = '0;
`ifdef AES_KEY_ZEROIZE_EN
        zero_a = 1'b0; zero_b = 1'b0;
`endif
        for (int x = 0; x < 256; x++) sbox_ref[x] = sbox_calc(8'(x));

        tick(); tick();
        chk("rst_busy_a",  128'(busy_a),  128'h0);
        chk("rst_ready_a", 128'(ready_a), 128'h0);
        chk("rst_busy_b",  128'(busy_b),  128'h0);
        chk("rst_ready_b", 128'(ready_b), 128'h0);
        #5 reset = 1'b0;
        tick();
        check_zero(0, "rst_a");
        check_zero(1, "rst_b");

        // T1 / T2: FIPS-197 vectors
        run(0, T1_KEY, 1'b0, "t1");
        rd(0, 1, v);  chk("t1_fips_rk1",  v, 128'ha0fafe1788542cb123a339392a6c7605);
        rd(0, 10, v); chk("t1_fips_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        run(1, T2_KEY, 1'b0, "t2");
        rd(1, 14, v); chk("t2_fips_rk14", v, 128'hfe4890d1e6188d0b046df344706c631e);

        // T3: start held during EXPAND with another key, out-of-range reads
        run(0, T1_KEY, 1'b1, "t3a");
        rd(0, 1, v);  chk("t3_rk1",  v, 128'ha0fafe1788542cb123a339392a6c7605);
        rd(0, 10, v); chk("t3_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd(0, 11, v); chk("t3_rd11_zero", v, 128'h0);
        run(1, T2_KEY, 1'b1, "t3b");
        rd(1, 15, v); chk("t3_rd15_zero", v, 128'h0);

        // T4: reset in cycle 5 of EXPAND
        rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        drive(0, 1'b1, rk); drive(1, 1'b1, rk);
        tick();
        drive(0, 1'b0, rk); drive(1, 1'b0, rk);
        for (int i = 0; i < 4; i++) tick();
        chk("t4_busy_before_reset", 128'(busy_a), 128'h1);
        #5 reset = 1'b1;
        #1;
        chk("t4_busy_a",  128'(busy_a),  128'h0);
        chk("t4_ready_a", 128'(ready_a), 128'h0);
        chk("t4_busy_b",  128'(busy_b),  128'h0);
        #5 reset = 1'b0;
        tick();
        check_zero(0, "t4a");
        check_zero(1, "t4b");
        run(0, {128'h0, rk[127:0]}, 1'b0, "t4_restart_a");
        run(1, rk, 1'b0, "t4_restart_b");

        // T5: restarts from DONE with random keys
        for (int n = 0; n < 3; n++) begin
            rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            chk($sformatf("t5_%0d_ready_before", n), 128'(ready_a), 128'h1);
            run(0, {128'h0, rk[255:128]}, 1'b0, $sformatf("t5_%0d_a", n));
            run(1, rk, 1'b0, $sformatf("t5_%0d_b", n));
        end

`ifdef AES_KEY_ZEROIZE_EN
        // T6: zeroize in DONE, then zeroize together with start
        zero_a = 1'b1;
        tick();
        zero_a = 1'b0;
        chk("t6_ready", 128'(ready_a), 128'h0);
        chk("t6_busy",  128'(busy_a),  128'h0);
        check_zero(0, "t6");
        zero_a = 1'b1; start_a = 1'b1; key_a = T1_KEY[127:0];
        tick();
        chk("t6_zs_busy",  128'(busy_a),  128'h0);
        chk("t6_zs_ready", 128'(ready_a), 128'h0);
        zero_a = 1'b0; start_a = 1'b0;
        tick();
        chk("t6_idle_busy", 128'(busy_a), 128'h0);
        rd(0, 0, v); chk("t6_rk0_zero", v, 128'h0);
        run(0, T1_KEY, 1'b0, "t6_restart");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
